// File: rtl/ahb_ram_sub.sv
// rtl/ahb_ram_sub.sv - AHB-Lite subordinate RAM with programmable wait states
//
// Purpose: DEPTH x AHBW word RAM behind an AHB-Lite decoder select. Single and
// burst transfers, LATENCY wait cycles on a non-burst data phase, two-cycle
// ERROR response for oversize or misaligned transfers.
//
// Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   HSELRam, HREADY      decoder select, bus-wide ready
//   HADDR, HWRITE, HTRANS, HSIZE, HBURST   address-phase controls
//   HWDATA, HWSTRB       data-phase write data and byte strobes
//   HREADRam             read data (held between read data phases)
//   HREADYRam, HRESPRam  HREADYOUT and response (1 = ERROR)

module ahb_ram_sub #(
  parameter int AHBW     = 64,
  parameter int PA_BITS  = 56,
  parameter int DEPTH    = 4096,
  parameter int LATENCY  = 0,
  parameter int BURST_EN = 1
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSELRam,
  input  logic [PA_BITS-1:0]  HADDR,
  input  logic                HWRITE,
  input  logic [1:0]          HTRANS,
  input  logic [2:0]          HSIZE,
  input  logic [2:0]          HBURST,
  input  logic                HREADY,
  input  logic [AHBW-1:0]     HWDATA,
  input  logic [AHBW/8-1:0]   HWSTRB,
  output logic [AHBW-1:0]     HREADRam,
  output logic                HREADYRam,
  output logic                HRESPRam
);

  localparam int BPW = AHBW / 8;
  localparam int OFF = $clog2(BPW);
  localparam int IW  = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IW-1:0]   idx_q;
  logic            write_q;
  logic [AHBW-1:0] rd_q;
  logic [AHBW-1:0] hold_q;
  logic [AHBW-1:0] fetch;
  logic [AHBW-1:0] mem [DEPTH];

  logic            accept;
  logic            take;
  logic            illegal;
  logic            wait_needed;
  logic            commit_now;
  logic [IW-1:0]   addr_idx;

  // Address bits above the word index are qualified by the decoder; burst
  // type is informational because beats are tracked through HTRANS.
  logic unused_ok;
  assign unused_ok = ^{HBURST, HADDR[PA_BITS-1:OFF+IW]};

  assign accept     = HSELRam & HREADY & HTRANS[1];
  assign addr_idx   = HADDR[OFF +: IW];
  assign commit_now = (state_q == S_DATA) && write_q;

  // A SEQ beat skips the wait states only when bursts are enabled.
  assign wait_needed = (LATENCY != 0) && !(HTRANS[0] && (BURST_EN != 0));

  always_comb begin
    illegal = (int'(HSIZE) > OFF);
    for (int i = 0; i < OFF; i++) begin
      if ((int'(HSIZE) > i) && HADDR[i]) illegal = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all close a data phase with HREADYRam=1, so a
        // pipelined address phase is accepted here under the same rules.
        state_d = S_IDLE;
        if (accept) begin
          take = 1'b1;
          if (illegal) begin
            state_d = S_ERR1;
          end else if (wait_needed) begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        idx_q   <= addr_idx;
        write_q <= HWRITE;
      end
      if ((state_q == S_DATA) && !write_q) hold_q <= rd_q;
    end
  end

  // Read word is fetched at the address-phase edge. If the write data phase
  // closing at that same edge targets the same index, its strobed bytes are
  // merged in so the read never sees the pre-write contents.
  always_comb begin
    fetch = mem[addr_idx];
    if (commit_now && (idx_q == addr_idx)) begin
      for (int b = 0; b < BPW; b++) begin
        if (HWSTRB[b]) fetch[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  // Array is deliberately not reset.
  always_ff @(posedge HCLK) begin
    if (HRESETn && commit_now) begin
      for (int b = 0; b < BPW; b++) begin
        if (HWSTRB[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
    if (HRESETn && take && !HWRITE) rd_q <= fetch;
  end

  assign HREADRam  = ((state_q == S_DATA) && !write_q) ? rd_q : hold_q;
  assign HREADYRam = !((state_q == S_WAIT) || (state_q == S_ERR1));
  assign HRESPRam  = (state_q == S_ERR1) || (state_q == S_ERR2);

endmodule
